// File: rtl/pe_shift_reg_file.sv
// rtl/pe_shift_reg_file.sv - PE register file with per-register hold/shift/load/clear and random read ports
// Optional feature macro: PE_RF_BYPASS_EN (read ports return the next-state value of a register being written)
module pe_shift_reg_file #(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic [DW-1:0]         din_res,
   input  logic                  res_valid,
   input  logic [DEPTH*DW-1:0]   din_ext,
   input  logic [2*DEPTH-1:0]    rf_inst,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [DEPTH*DW-1:0]   dout,
   output logic [DEPTH-1:0]      dout_valid,
   output logic [NRD*DW-1:0]     rd_data,
   output logic [DW-1:0]         evict_data,
   output logic                  evict_valid
);

   localparam logic [1:0] OP_HOLD  = 2'b00;
   localparam logic [1:0] OP_SHIFT = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // Read address space is a full power of two; slots past DEPTH read as zero.
   localparam int NSLOT = 1 << AW;

   logic [DW-1:0]    r_q     [DEPTH];
   logic [DW-1:0]    r_d     [DEPTH];
   logic [DW-1:0]    sh_data [DEPTH];
   logic [DEPTH-1:0] sh_valid;
   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [DW-1:0]    rd_src  [NSLOT];
   logic             evict_fire;

   // Shift source for each register: R0 takes the PE result, Ri takes R(i-1).
   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_shift_src
         if (g == 0) begin : g_head
            assign sh_data[g] = din_res;
         end else begin : g_body
            assign sh_data[g] = r_q[g-1];
         end
         assign dout[g*DW +: DW] = r_q[g];
      end
   endgenerate

   assign sh_valid   = {v_q[DEPTH-2:0], res_valid};
   assign dout_valid = v_q;

   // The top register spills only when it is shifted while holding valid data.
   assign evict_fire = !stall && (rf_inst[2*DEPTH-1 -: 2] == OP_SHIFT) && v_q[DEPTH-1];

   // Next-state per register from its own opcode, using only pre-edge values.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         r_d[i] = r_q[i];
         v_d[i] = v_q[i];
         case (rf_inst[2*i +: 2])
            OP_HOLD: begin
               r_d[i] = r_q[i];
               v_d[i] = v_q[i];
            end
            OP_SHIFT: begin
               r_d[i] = sh_data[i];
               v_d[i] = sh_valid[i];
            end
            OP_LOAD: begin
               r_d[i] = din_ext[i*DW +: DW];
               v_d[i] = 1'b1;
            end
            OP_CLEAR: begin
               r_d[i] = '0;
               v_d[i] = 1'b0;
            end
            default: begin
               r_d[i] = r_q[i];
               v_d[i] = v_q[i];
            end
         endcase
      end
   end

   // Register, valid and evict state; reset wins over stall and opcodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q[i] <= '0;
         end
         v_q         <= '0;
         evict_data  <= '0;
         evict_valid <= 1'b0;
      end else begin
         evict_valid <= evict_fire;
         if (evict_fire) begin
            evict_data <= r_q[DEPTH-1];
         end
         if (!stall) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_q[i] <= r_d[i];
            end
            v_q <= v_d;
         end
      end
   end

   // Per-slot read source; a stalled register never presents its next state.
   generate
      for (g = 0; g < NSLOT; g++) begin : g_rd_src
         if (g < DEPTH) begin : g_real
`ifdef PE_RF_BYPASS_EN
            assign rd_src[g] = stall ? r_q[g] : r_d[g];
`else
            assign rd_src[g] = r_q[g];
`endif
         end else begin : g_empty
            assign rd_src[g] = '0;
         end
      end
   endgenerate

   // Random-access read ports.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_data[k*DW +: DW] = rd_src[rd_addr[k*AW +: AW]];
      end
   end

endmodule

// File: tb/tb_pe_shift_reg_file.sv
// tb/tb_pe_shift_reg_file.sv - self-checking bench for pe_shift_reg_file
module tb_pe_shift_reg_file;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic [31:0]   din_res;
   logic          res_valid;
   logic [127:0]  din_ext;
   logic [7:0]    rf_inst;
   logic [3:0]    rd_addr;
   logic [127:0]  dout;
   logic [3:0]    dout_valid;
   logic [63:0]   rd_data;
   logic [31:0]   evict_data;
   logic          evict_valid;

   logic [191:0]  d6_din_ext;
   logic [11:0]   d6_inst;
   logic [2:0]    d6_rd_addr;
   logic [191:0]  d6_dout;
   logic [5:0]    d6_dout_valid;
   logic [31:0]   d6_rd_data;
   logic [31:0]   d6_evict_data;
   logic          d6_evict_valid;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   logic [31:0] m_r [4];
   logic [3:0]  m_v;
   logic [31:0] m_evd;
   logic        m_evv;

   pe_shift_reg_file #(.DW(32), .DEPTH(4), .NRD(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .din_res(din_res), .res_valid(res_valid),
      .din_ext(din_ext), .rf_inst(rf_inst), .rd_addr(rd_addr), .dout(dout),
      .dout_valid(dout_valid), .rd_data(rd_data), .evict_data(evict_data),
      .evict_valid(evict_valid)
   );

   pe_shift_reg_file #(.DW(32), .DEPTH(6), .NRD(1)) dut6 (
      .clk(clk), .rst(rst), .stall(1'b0), .din_res(32'h0), .res_valid(1'b0),
      .din_ext(d6_din_ext), .rf_inst(d6_inst), .rd_addr(d6_rd_addr), .dout(d6_dout),
      .dout_valid(d6_dout_valid), .rd_data(d6_rd_data), .evict_data(d6_evict_data),
      .evict_valid(d6_evict_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Value register i must hold after the next edge, by the opcode rules.
   function automatic logic [31:0] nxt_r(input int i);
      case (rf_inst[2*i +: 2])
         2'b01:   return (i == 0) ? din_res : m_r[(i == 0) ? 0 : i - 1];
         2'b10:   return din_ext[32*i +: 32];
         2'b11:   return 32'h0;
         default: return m_r[i];
      endcase
   endfunction

   function automatic logic nxt_v(input int i);
      case (rf_inst[2*i +: 2])
         2'b01:   return (i == 0) ? res_valid : m_v[(i == 0) ? 0 : i - 1];
         2'b10:   return 1'b1;
         2'b11:   return 1'b0;
         default: return m_v[i];
      endcase
   endfunction

   function automatic logic [31:0] exp_rd(input int a);
      if (a >= 4) return 32'h0;
`ifdef PE_RF_BYPASS_EN
      if (!stall) return nxt_r(a);
`endif
      return m_r[a];
   endfunction

   // Reference model state advance.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) m_r[i] <= 32'h0;
         m_v   <= 4'h0;
         m_evd <= 32'h0;
         m_evv <= 1'b0;
      end else begin
         m_evv <= !stall && (rf_inst[7:6] == 2'b01) && m_v[3];
         if (!stall && (rf_inst[7:6] == 2'b01) && m_v[3]) m_evd <= m_r[3];
         if (!stall) begin
            for (int i = 0; i < 4; i++) begin
               m_r[i] <= nxt_r(i);
               m_v[i] <= nxt_v(i);
            end
         end
      end
   end

   // Every-cycle comparison of DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 4; i++) chk($sformatf("dout_r%0d", i), dout[32*i +: 32], m_r[i]);
         chk("dout_valid", dout_valid, m_v);
         chk("evict_valid", evict_valid, m_evv);
         chk("evict_data", evict_data, m_evd);
         for (int k = 0; k < 2; k++)
            chk($sformatf("rd_data_p%0d", k), rd_data[32*k +: 32], exp_rd(int'(rd_addr[2*k +: 2])));
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; rf_inst = 8'hFF; din_res = 32'h0; res_valid = 1'b0;
      din_ext = '0; rd_addr = 4'h0; d6_din_ext = '0; d6_inst = 12'h0; d6_rd_addr = 3'h0;

      // Reset with all-CLEAR opcodes.
      cyc();
      chk("reset_dout", dout, 128'h0);
      chk("reset_valid", dout_valid, 4'h0);
      chk("reset_evict", evict_valid, 1'b0);
      chk_en = 1'b1;

      // Full shift chain.
      rst = 1'b0; rf_inst = 8'h55; res_valid = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         din_res = n;
         cyc();
         if (n == 4) begin
            chk("shift4_dout", dout, {32'd1, 32'd2, 32'd3, 32'd4});
            chk("shift4_valid", dout_valid, 4'hF);
            chk("shift4_evict", evict_valid, 1'b0);
         end
      end
      chk("shift5_evict_valid", evict_valid, 1'b1);
      chk("shift5_evict_data", evict_data, 32'd1);
      chk("shift5_dout", dout, {32'd2, 32'd3, 32'd4, 32'd5});

      // Stall overrides CLEAR.
      stall = 1'b1; rf_inst = 8'hFF; din_res = 32'd6;
      cyc();
      chk("stall_dout", dout, {32'd2, 32'd3, 32'd4, 32'd5});
      chk("stall_valid", dout_valid, 4'hF);
      chk("stall_evict", evict_valid, 1'b0);
      stall = 1'b0;

      // Load everything, then exercise read ports.
      rf_inst = 8'hAA;
      din_ext = {32'h4444, 32'h1234, 32'h2222, 32'h1111};
      d6_inst = 12'hAAA;
      d6_din_ext = {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
      cyc();
      rf_inst = 8'h00; d6_inst = 12'h000;
      rd_addr = {2'd3, 2'd2}; d6_rd_addr = 3'd7;
      #1;
      chk("rd_p0_addr2", rd_data[31:0], 32'h1234);
      chk("rd_p1_addr3", rd_data[63:32], 32'h4444);
      chk("d6_rd_addr7", d6_rd_data, 32'h0);
      d6_rd_addr = 3'd6;
      #1;
      chk("d6_rd_addr6", d6_rd_data, 32'h0);
      d6_rd_addr = 3'd5;
      #1;
      chk("d6_rd_addr5", d6_rd_data, 32'h66);
      cyc();

      // Mixed: R1 load, R2 shift (takes old R1), R0/R3 hold.
      rf_inst = 8'h18; din_ext = {32'h0, 32'h0, 32'h99, 32'h0};
      cyc();
      chk("mixed_dout", dout, {32'h4444, 32'h2222, 32'h99, 32'h1111});

      // Write-through read of R0 while it loads.
      rf_inst = 8'h02; din_ext = {96'h0, 32'hAB}; rd_addr = {2'd1, 2'd0};
      #1;
`ifdef PE_RF_BYPASS_EN
      chk("bypass_rd_p0", rd_data[31:0], 32'hAB);
`else
      chk("nobypass_rd_p0", rd_data[31:0], 32'h1111);
`endif
      cyc();
      chk("load_r0", dout[31:0], 32'hAB);

      // R3 clear (no evict), R0 shifts in an invalid result.
      rf_inst = 8'hC1; din_res = 32'h77; res_valid = 1'b0;
      cyc();
      chk("clear_valid", dout_valid, 4'b0110);
      chk("clear_evict", evict_valid, 1'b0);
      chk("clear_r3", dout[127:96], 32'h0);

      // Shift with bubbles.
      rf_inst = 8'h55;
      for (int n = 0; n < 6; n++) begin
         res_valid = ~n[0];
         din_res = 32'h100 + n;
         cyc();
      end

      // Reset mid-shift with a valid top register: no evict pulse.
      rst = 1'b1; res_valid = 1'b1;
      cyc();
      chk("midrst_evict", evict_valid, 1'b0);
      chk("midrst_dout", dout, 128'h0);
      chk("midrst_valid", dout_valid, 4'h0);
      chk("midrst_evd", evict_data, 32'h0);

      // First edge out of reset executes normally.
      rst = 1'b0; rf_inst = 8'h02; din_ext = {96'h0, 32'h5A};
      cyc();
      chk("postrst_r0", dout[31:0], 32'h5A);
      chk("postrst_valid", dout_valid, 4'b0001);

      // Random traffic against the model.
      for (int n = 0; n < 80; n++) begin
         stall = ($urandom_range(0, 3) == 0);
         rf_inst = 8'($urandom);
         din_res = $urandom;
         res_valid = 1'($urandom);
         din_ext = {$urandom, $urandom, $urandom, $urandom};
         rd_addr = 4'($urandom);
         cyc();
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
